// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled counter family.
// Derives the prescaler divide ratio and width from clock/tick rates.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Zero flags an illegal rate pair; the top rejects it at elaboration.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_pre_w(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV prescaler producing a one-cycle enable tick.
// Holds its phase while en is low; clr restarts the period from zero.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_int
);

  localparam int PRE_W = calc_pre_w(DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick_int = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/counter_prescaled_updown.sv
// Up/down modulo counter advanced by an internal prescaler tick, with
// clamped load, wrap-or-saturate range ends and registered chaining pulses.
module counter_prescaled_updown
  import counter_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 6,
  parameter int CNT_MAX = 59,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             tc
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  if (DIV < 1) begin : g_bad_div
    $fatal(1, "counter_prescaled_updown: DIV must be >= 1");
  end
  if (TICK_HZ > 0 && (CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
    $fatal(1, "counter_prescaled_updown: CLK_HZ not a multiple of TICK_HZ");
  end
  if (64'(CNT_MAX) >= (64'd1 << CNT_W)) begin : g_bad_max
    $fatal(1, "counter_prescaled_updown: CNT_MAX does not fit CNT_W");
  end

  logic             tick_int;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  // Load restarts the tick period so the next tick is a full DIV away.
  tick_prescaler #(.DIV(DIV)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (load),
    .tick_int (tick_int)
  );

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (tick_int) begin
      tick_d = 1'b1;
      if (up_dn == CNT_UP) begin
        if (cnt_q == MAX_V) begin
          tc_d  = 1'b1;
          cnt_d = (WRAP != 0) ? '0 : MAX_V;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          cnt_d = (WRAP != 0) ? MAX_V : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  // tick is a one-cycle valid strobe for cnt (no ready): a chained stage
  // must consume cnt/tc in the cycle tick is high.
  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_counter_prescaled_updown.sv
// Three counters (59/wrap, 5/wrap, 5/saturate) share one stimulus stream and are
// scored against a per-cycle count model plus a cycle-stamped tick queue.
module tb_counter_prescaled_updown;

  localparam int DIV = 10;
  localparam int W   = 32 + 6 + 1;

  logic clk = 1'b0;
  logic rst, cnt_en, up_dn, load;
  logic [5:0] load_val;
  logic [5:0] d_cnt [3];
  logic       d_tick [3];
  logic       d_tc [3];

  int checks = 0;
  int errors = 0;

  int mmax [3] = '{59, 5, 5};
  bit mwrap [3] = '{1'b1, 1'b1, 1'b0};
  int m_cnt [3] = '{0, 0, 0};
  int phase = 0;
  int s = 0;
  int mon_s = 0;

  logic [5:0]   cnt_q [3][$];
  logic [W-1:0] exp_q [3][$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  counter_prescaled_updown #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(6), .CNT_MAX(59), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(d_cnt[0]), .tick(d_tick[0]), .tc(d_tc[0]));
  counter_prescaled_updown #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(6), .CNT_MAX(5), .WRAP(1)) u_b (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(d_cnt[1]), .tick(d_tick[1]), .tc(d_tc[1]));
  counter_prescaled_updown #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(6), .CNT_MAX(5), .WRAP(0)) u_c (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(d_cnt[2]), .tick(d_tick[2]), .tc(d_tc[2]));

  task automatic check(input string name, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d", name, i, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_edge(input bit r, input bit en, input bit ld, input int lv, input bit up);
    bit tk;
    bit hit;
    tk = 1'b0;
    if (r || ld) phase = 0;
    else if (en) begin
      phase++;
      if (phase == DIV) begin
        phase = 0;
        tk = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      if (r) m_cnt[i] = 0;
      else if (ld) m_cnt[i] = (lv > mmax[i]) ? mmax[i] : lv;
      else if (tk) begin
        if (up) begin
          if (m_cnt[i] == mmax[i]) begin
            hit = 1'b1;
            m_cnt[i] = mwrap[i] ? 0 : mmax[i];
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            hit = 1'b1;
            m_cnt[i] = mwrap[i] ? mmax[i] : 0;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
      cnt_q[i].push_back(6'(m_cnt[i]));
      if (tk) exp_q[i].push_back({32'(s), 6'(m_cnt[i]), hit});
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit en, input bit ld, input int lv, input bit up);
    @(negedge clk);
    rst = r; cnt_en = en; load = ld; load_val = 6'(lv); up_dn = up;
    @(posedge clk);
    s++;
    model_edge(r, en, ld, lv, up);
  endtask

  task automatic run(input int n, input bit en, input bit up);
    for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0, up);
  endtask

  task automatic anchor(input string name, input int i, input int ecnt, input bit etick, input bit etc);
    #1;
    check({name, "_cnt"}, i, int'(d_cnt[i]), ecnt);
    check({name, "_tick"}, i, int'(d_tick[i]), int'(etick));
    check({name, "_tc"}, i, int'(d_tc[i]), int'(etc));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (cnt_q[0].size() > 0) begin
      mon_s++;
      for (int i = 0; i < 3; i++) begin
        check("cnt", i, int'(d_cnt[i]), int'(cnt_q[i].pop_front()));
        while (exp_q[i].size() > 0 && int'(exp_q[i][0][W-1 -: 32]) < mon_s) begin
          e = exp_q[i].pop_front();
          checks++; errors++;
          $display("FAIL missed_tick dut%0d got none expected tick at step %0d", i, int'(e[W-1 -: 32]));
        end
        if (d_tc[i] && !d_tick[i]) begin
          checks++; errors++;
          $display("FAIL tc_without_tick dut%0d got tc=1 tick=0 expected tc=0 at step %0d", i, mon_s);
        end
        if (d_tick[i] === 1'b1) begin
          if (exp_q[i].size() == 0 || int'(exp_q[i][0][W-1 -: 32]) != mon_s) begin
            checks++; errors++;
            $display("FAIL extra_tick dut%0d got tick=1 expected tick=0 at step %0d", i, mon_s);
          end else begin
            e = exp_q[i].pop_front();
            check("tick_cnt", i, int'(d_cnt[i]), int'(e[6:1]));
            check("tick_tc", i, int'(d_tc[i]), int'(e[0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cnt_en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    anchor("reset", 0, 0, 0, 0);
    run(10, 1, 1);
    for (int i = 0; i < 3; i++) anchor("first_tick", i, 1, 1, 0);
    run(30, 1, 1);
    for (int i = 0; i < 3; i++) anchor("forty", i, 4, 1, 0);

    run(5, 1, 1);
    run(20, 0, 1);
    run(5, 1, 1);
    for (int i = 0; i < 3; i++) anchor("pause", i, 5, 1, 0);

    step(0, 1, 1, 5, 1);
    run(10, 1, 1);
    anchor("up_wrap", 1, 0, 1, 1);
    anchor("up_sat", 2, 5, 1, 1);
    anchor("up_mid", 0, 6, 1, 0);
    run(10, 1, 1);
    anchor("up_sat2", 2, 5, 1, 1);
    anchor("up_after_wrap", 1, 1, 1, 0);

    step(0, 1, 1, 0, 0);
    run(10, 1, 0);
    anchor("dn_wrap59", 0, 59, 1, 1);
    anchor("dn_wrap5", 1, 5, 1, 1);
    anchor("dn_sat", 2, 0, 1, 1);
    run(10, 1, 0);
    anchor("dn_next", 1, 4, 1, 0);
    anchor("dn_next59", 0, 58, 1, 0);

    step(0, 0, 1, 63, 1);
    anchor("clamp59", 0, 59, 0, 0);
    anchor("clamp5", 1, 5, 0, 0);
    run(9, 1, 1);
    step(0, 1, 1, 10, 1);
    anchor("load_wins", 0, 10, 0, 0);
    run(9, 1, 1);
    anchor("no_early_tick", 0, 10, 0, 0);
    run(1, 1, 1);
    anchor("tick_after_load", 0, 11, 1, 0);

    step(0, 1, 1, 3, 1);
    run(7, 1, 1);
    step(1, 1, 1, 20, 1);
    for (int i = 0; i < 3; i++) anchor("mid_reset", i, 0, 0, 0);
    run(10, 1, 1);
    for (int i = 0; i < 3; i++) anchor("post_reset_tick", i, 1, 1, 0);

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < 3, int'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("pending_ticks", i, exp_q[i].size(), 0);
      check("pending_cnt", i, cnt_q[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_prescaled_updown.md
Name: counter_prescaled_updown

Overview:
Parametrised successor to the single-rate 6-bit divided-clock counter. An internal prescaler derives an enable tick at TICK_HZ from the CLK_HZ system clock. A CNT_W-bit modulo counter advances on each tick. Adds:
- up/down direction
- synchronous load with clamping
- configurable modulus
- wrap or saturate mode
- registered tick and terminal-count pulses for chaining (e.g. seconds -> minutes on the Basys 3 display path)

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ (integer, >= 1)
CNT_W, 6, counter width in bits
CNT_MAX, 59, highest count value; counter range is 0..CNT_MAX (must be < 2**CNT_W)
WRAP, 1, 1 = wrap at the range ends, 0 = saturate at the range ends

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
cnt_en  in  1  count enable; gates the prescaler
up_dn  in  1  1 = count up, 0 = count down; sampled on tick edges only
load  in  1  synchronous load strobe
load_val  in  CNT_W  value to load
cnt  out  CNT_W  current count, registered
tick  out  1  one-cycle pulse, high in the cycle in which cnt first shows a tick-updated value
tc  out  1  one-cycle pulse, high alongside tick when the update hit a range end

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Priority on each edge: rst > load > tick-count > hold.
- Reset values: cnt=0, prescaler=0, tick=0, tc=0. Reset asserted mid-count takes effect at the next edge regardless of cnt_en or load. The first tick comes DIV enabled cycles after rst deasserts.
- Prescaler:
  - Width PRE_W = max(1, clog2(DIV)).
  - When cnt_en=1 it counts 0..DIV-1. At DIV-1 it returns to 0 and raises an internal tick_int for that cycle.
  - When cnt_en=0 it holds its value, so phase is preserved across a pause.
  - DIV=1: tick_int is high every enabled cycle.
- Count on the edge where tick_int=1 and no load:
  - up, cnt<CNT_MAX: cnt+1.
  - up, cnt==CNT_MAX: WRAP=1 -> 0; WRAP=0 -> hold at CNT_MAX. tc=1 in both cases.
  - down, cnt>0: cnt-1.
  - down, cnt==0: WRAP=1 -> CNT_MAX; WRAP=0 -> hold at 0. tc=1 in both cases.
- Output pulses:
  - tick is registered from tick_int. It is high for exactly one cycle, the cycle after the tick edge, aligned with the new cnt.
  - tc is registered the same way and is only ever high together with tick.
- Load:
  - cnt <= load_val if load_val <= CNT_MAX, else cnt <= CNT_MAX (clamp).
  - The prescaler is cleared to 0.
  - tick and tc are 0 in the following cycle, even if tick_int was due that edge (load wins).
- Load with cnt_en=0 still loads.
- up_dn changes between ticks have no effect until the next tick edge.
- All arithmetic is CNT_W bits unsigned. No intermediate overflow is possible because range ends are handled before the increment or decrement.
- Elaboration: fatal error if DIV < 1, if CLK_HZ % TICK_HZ != 0, or if CNT_MAX >= 2**CNT_W.

Decomposition:
- Shared package counter_pkg holds:
  - the clog2 constant function
  - the DIV/PRE_W derivation
  - the direction constants CNT_UP=1 and CNT_DN=0
- One sub-module, tick_prescaler:
  - parameter DIV
  - ports clk, rst, en, clr, tick_int
  - reused by future display-multiplex and debounce blocks
- The top-level module holds the count register, the range/mode logic and the output pulse registers.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10) and CNT_W=6 unless stated.
1. Reset and up-count: rst=1 for 2 cycles, then cnt_en=1, up_dn=1 -> tick high at cycle 11 with cnt=1; cnt=4 after 40 enabled cycles; tc never high.
2. Pause: drop cnt_en after 5 enabled cycles, hold 20 cycles, re-enable -> next tick exactly 5 enabled cycles later; cnt unchanged during the pause.
3. Up wrap/saturate: CNT_MAX=5, load 5, one tick -> WRAP=1 gives cnt=0 with tick=tc=1; WRAP=0 gives cnt=5 with tick=tc=1; subsequent ticks keep cnt=5 and pulse tc each tick.
4. Down wrap: CNT_MAX=5, WRAP=1, load 0, up_dn=0, one tick -> cnt=5, tc=1; the next tick gives cnt=4, tc=0.
5. Load clamp and collision: CNT_MAX=59, load_val=63 -> cnt=59. Load asserted on the same edge as tick_int with load_val=10 -> cnt=10, tick=0 next cycle; the next tick comes 10 enabled cycles later.
6. Reset mid-operation: with prescaler=7, cnt=3, pulse rst for 1 cycle -> cnt=0, tick=tc=0 next cycle; first tick 10 enabled cycles after release, cnt=1.
